axil2apb_bridge: RTL and testbench
==================================

AXIL2APB_BRIDGE -- requirements
Module: axil2apb_bridge

Interface
REQ-001 Parameter C_APB_ADDR_WIDTH, default 12, address width AW for both the AXI-Lite and APB sides.
REQ-002 Parameter C_APB_DATA_WIDTH, default 32, data width DW; legal values are 32 and 64.
REQ-003 Ports are listed clock first, then reset, then as follows (name, direction, width, meaning):
- PCLK  in  1  the single clock for all logic.
- PRESETn  in  1  asynchronous, active-low reset.
REQ-004 S_AXI_AWVALID/AWREADY in/out 1; S_AXI_AWADDR in AW; S_AXI_AWPROT in 3: write-address channel.
REQ-005 S_AXI_WVALID/WREADY in/out 1; S_AXI_WDATA in DW; S_AXI_WSTRB in DW/8: write-data channel.
REQ-006 S_AXI_BVALID/BREADY out/in 1; S_AXI_BRESP out 2: write-response channel.
REQ-007 S_AXI_ARVALID/ARREADY in/out 1; S_AXI_ARADDR in AW; S_AXI_ARPROT in 3: read-address channel.
REQ-008 S_AXI_RVALID/RREADY out/in 1; S_AXI_RDATA out DW; S_AXI_RRESP out 2: read-data channel.
REQ-009 APB master ports: PSEL, PENABLE, PWRITE out 1; PADDR out AW; PWDATA out DW; PWSTRB out DW/8; PPROT out 3; PREADY, PSLVERR in 1; PRDATA in DW.

Function
REQ-010 The bridge SHALL have one transaction outstanding at most and SHALL use FSM states IDLE, SETUP, ACCESS, WRESP and RRESP.
REQ-011 In IDLE, a write is eligible only when AWVALID and WVALID are both high; a read is eligible when ARVALID is high.
REQ-012 When both a write and a read are eligible, the bridge SHALL grant the type not granted last (round-robin); the last-granted flag resets to "read", so the first contended grant goes to the write.
REQ-013 AWREADY and WREADY SHALL assert together, combinationally, only in IDLE on a write grant; ARREADY SHALL assert only in IDLE on a read grant.
REQ-014 On a grant, the bridge SHALL register PADDR, PWRITE and PPROT, plus PWDATA and PWSTRB for writes (PWDATA=0 and PWSTRB=0 for reads), and enter SETUP.
REQ-015 In SETUP, the bridge SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then enter ACCESS.
REQ-016 In ACCESS, the bridge SHALL hold PSEL=1, PENABLE=1 and all P* outputs stable until PREADY=1; wait states are unbounded.
REQ-017 On the ACCESS cycle with PREADY=1, the bridge SHALL deassert PSEL and PENABLE on the next cycle.
REQ-017a On that same cycle, the bridge SHALL register the response as BRESP or RRESP = PSLVERR ? 2'b10 : 2'b00, and capture PRDATA into RDATA for reads.
REQ-017b On that same cycle, the bridge SHALL enter WRESP with BVALID=1 for a write, or RRESP with RVALID=1 for a read.
REQ-018 BVALID/RVALID and their payloads SHALL hold until BREADY/RREADY; on the handshake cycle, the FSM SHALL return to IDLE.
REQ-019 No new address SHALL be accepted in the cycle of a B or R handshake; the earliest next acceptance is the following cycle.
REQ-020 Minimum latency, with a zero-wait APB slave: address handshake in cycle N, SETUP in N+1, ACCESS with PREADY in N+2, BVALID/RVALID in N+3.
REQ-021 PSLVERR SHALL be sampled only when PSEL&&PENABLE&&PREADY; PRDATA SHALL be sampled only on reads at that same point.
REQ-022 AW without W (or W without AW) SHALL NOT be accepted, and a pending read in that case SHALL be granted.
REQ-023 Address bits below log2(DW/8) SHALL be passed through unmodified on PADDR.

Reset
REQ-024 Assertion of PRESETn low SHALL asynchronously force the FSM to IDLE and the last-granted flag to "read".
REQ-024a Assertion of PRESETn low SHALL asynchronously force PSEL, PENABLE, BVALID and RVALID to 0.
REQ-024b Assertion of PRESETn low SHALL asynchronously force PADDR, PWRITE, PWDATA, PWSTRB, PPROT, BRESP, RRESP and RDATA to 0.
REQ-025 A reset during SETUP, ACCESS or a pending response SHALL abandon the transaction, with no response issued afterwards.
REQ-026 Reset deassertion SHALL be used synchronously to PCLK; no READY output may assert in the first cycle after release.

Structure
REQ-027 FSM state encodings and the OKAY(2'b00)/SLVERR(2'b10) constants SHALL reside in a shared package, axil2apb_pkg.
REQ-028 The block SHALL be a single module with no sub-modules; the datapath registers and FSM live in one file.

Verification
REQ-029 Write AWADDR=0x010, WDATA=0x12345678, WSTRB=4'hF, with a zero-wait slave -> one SETUP plus one ACCESS cycle, PADDR=0x010, then BVALID at N+3 with BRESP=00.
REQ-030 Read ARADDR=0x010, slave returns 0x87654321 after 3 wait states -> PENABLE held 4 cycles with stable P* outputs, then RDATA=0x87654321 and RRESP=00.
REQ-031 Simultaneous AW/W and AR valid from reset, for three transactions each -> grant order W,R,W,R,W,R with no APB overlap.
REQ-032 Slave returns PSLVERR=1 on a read -> RRESP=10, with the bridge ready for the next transaction after RREADY.
REQ-033 BREADY held low for 5 cycles with ARVALID pending -> ARREADY stays 0 until the cycle after the B handshake.
REQ-034 PRESETn pulsed low mid-ACCESS -> PSEL and PENABLE fall without waiting for a clock edge, and no BVALID/RVALID appears after release.

Source files
------------

// File: rtl/axil2apb_pkg.sv
// Shared FSM encoding and APB->AXI response codes for the AXI-Lite to APB bridge.
package axil2apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] apb_resp(input logic slverr);
        return slverr ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil2apb_bridge_if.sv
// AXI-Lite slave + APB master signal bundle; 'slave' is the bridge view, 'master' the environment view.
interface axil2apb_bridge_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic            S_AXI_AWVALID, S_AXI_AWREADY;
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_WVALID, S_AXI_WREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_ARVALID, S_AXI_ARREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_RVALID, S_AXI_RREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;

    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW/8-1:0] PWSTRB;
    logic [2:0]      PPROT;
    logic            PREADY, PSLVERR;
    logic [DW-1:0]   PRDATA;

    modport slave (
        input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
        output S_AXI_AWREADY,
        input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
        output S_AXI_WREADY,
        output S_AXI_BVALID, S_AXI_BRESP,
        input  S_AXI_BREADY,
        input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
        output S_AXI_ARREADY,
        output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
        input  S_AXI_RREADY,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT,
        input  PREADY, PSLVERR, PRDATA
    );

    modport master (
        output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
        input  S_AXI_AWREADY,
        output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
        input  S_AXI_WREADY,
        input  S_AXI_BVALID, S_AXI_BRESP,
        output S_AXI_BREADY,
        output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
        input  S_AXI_ARREADY,
        input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
        output S_AXI_RREADY,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT,
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/axil2apb_bridge.sv
// Single-outstanding AXI-Lite to APB bridge with round-robin write/read arbitration.
module axil2apb_bridge
    import axil2apb_pkg::*;
#(
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    axil2apb_bridge_if.slave   bus
);
    localparam int AW = C_APB_ADDR_WIDTH;
    localparam int DW = C_APB_DATA_WIDTH;

    state_e          state, state_nxt;
    logic            last_rd;
    logic            rst_done;
    logic            wr_elig, rd_elig, grant_wr, grant_rd, apb_done;

    logic [AW-1:0]   paddr_q;
    logic            pwrite_q;
    logic [2:0]      pprot_q;
    logic [DW-1:0]   pwdata_q, rdata_q;
    logic [DW/8-1:0] pwstrb_q;
    logic [1:0]      bresp_q, rresp_q;

    always_comb begin
        wr_elig   = bus.S_AXI_AWVALID && bus.S_AXI_WVALID;
        rd_elig   = bus.S_AXI_ARVALID;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        apb_done  = (state == ACCESS) && bus.PREADY;
        state_nxt = state;
        case (state)
            // rst_done keeps the first post-reset cycle quiet; ties go to whichever type lost last
            IDLE: if (rst_done) begin
                if (wr_elig && (!rd_elig || last_rd)) begin
                    grant_wr  = 1'b1;
                    state_nxt = SETUP;
                end else if (rd_elig) begin
                    grant_rd  = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.PREADY) state_nxt = pwrite_q ? WRESP : RRESP;
            WRESP:   if (bus.S_AXI_BREADY) state_nxt = IDLE;
            RRESP:   if (bus.S_AXI_RREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            last_rd  <= 1'b1;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (grant_wr)      last_rd <= 1'b0;
            else if (grant_rd) last_rd <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pprot_q  <= '0;
            pwdata_q <= '0;
            pwstrb_q <= '0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (grant_wr) begin
                paddr_q  <= bus.S_AXI_AWADDR;
                pwrite_q <= 1'b1;
                pprot_q  <= bus.S_AXI_AWPROT;
                pwdata_q <= bus.S_AXI_WDATA;
                pwstrb_q <= bus.S_AXI_WSTRB;
            end else if (grant_rd) begin
                paddr_q  <= bus.S_AXI_ARADDR;
                pwrite_q <= 1'b0;
                pprot_q  <= bus.S_AXI_ARPROT;
                pwdata_q <= '0;
                pwstrb_q <= '0;
            end
            // PSLVERR/PRDATA are only meaningful on the completing ACCESS cycle
            if (apb_done) begin
                if (pwrite_q) begin
                    bresp_q <= apb_resp(bus.PSLVERR);
                end else begin
                    rresp_q <= apb_resp(bus.PSLVERR);
                    rdata_q <= bus.PRDATA;
                end
            end
        end
    end

    assign bus.S_AXI_AWREADY = grant_wr;
    assign bus.S_AXI_WREADY  = grant_wr;
    assign bus.S_AXI_ARREADY = grant_rd;
    assign bus.S_AXI_BVALID  = (state == WRESP);
    assign bus.S_AXI_BRESP   = bresp_q;
    assign bus.S_AXI_RVALID  = (state == RRESP);
    assign bus.S_AXI_RRESP   = rresp_q;
    assign bus.S_AXI_RDATA   = rdata_q;

    assign bus.PSEL    = (state == SETUP) || (state == ACCESS);
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWSTRB  = pwstrb_q;
    assign bus.PPROT   = pprot_q;

endmodule

// File: tb/tb_axil2apb_bridge.sv
// Directed bench for axil2apb_bridge: APB slave model with programmable wait states and hand-computed expectations.
module tb_axil2apb_bridge;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    axil2apb_bridge_if #(.AW(12), .DW(32)) bus();

    axil2apb_bridge #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int vecs = 0;
    int errs = 0;

    // APB slave model
    int          wait_n;
    logic [31:0] slv_rdata;
    logic        slv_err;
    int          cnt;

    assign bus.PREADY  = bus.PSEL && bus.PENABLE && (cnt == wait_n);
    assign bus.PRDATA  = bus.PREADY ? slv_rdata : 32'hDEADBEEF;
    assign bus.PSLVERR = bus.PREADY && slv_err;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                     cnt <= 0;
        else if (bus.PSEL && bus.PENABLE && !bus.PREADY)  cnt <= cnt + 1;
        else                                              cnt <= 0;
    end

    // APB monitor: overlap, stability in ACCESS, completion order
    logic        prev_psel   = 1'b0;
    int          overlap_err = 0;
    int          stab_err    = 0;
    logic [7:0]  apb_ord     = '0;
    logic [11:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_strb;
    logic [2:0]  snap_prot;
    logic        snap_write;

    always @(posedge PCLK) begin
        prev_psel <= bus.PSEL;
        if (bus.PSEL && !bus.PENABLE) begin
            if (prev_psel) overlap_err <= overlap_err + 1;
            snap_addr  <= bus.PADDR;
            snap_wdata <= bus.PWDATA;
            snap_strb  <= bus.PWSTRB;
            snap_prot  <= bus.PPROT;
            snap_write <= bus.PWRITE;
        end
        if (bus.PSEL && bus.PENABLE) begin
            if (bus.PADDR !== snap_addr || bus.PWDATA !== snap_wdata || bus.PWSTRB !== snap_strb ||
                bus.PPROT !== snap_prot || bus.PWRITE !== snap_write)
                stab_err <= stab_err + 1;
            if (bus.PREADY) apb_ord <= {apb_ord[6:0], bus.PWRITE};
        end
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset;
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        bus.S_AXI_AWADDR = 12'h040; bus.S_AXI_AWPROT = 3'b0; bus.S_AXI_WDATA = 32'h1; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 12'h044; bus.S_AXI_ARPROT = 3'b0;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        #1;
        vecs++;
        if ({bus.PSEL, bus.PENABLE, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 4'b0000) begin
            errs++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.PSEL, bus.PENABLE, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
        vecs++;
        if ({bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT} !== '0) begin
            errs++; $display("FAIL reset_apb_regs: got addr=%h w=%b wd=%h st=%h pr=%h expected all 0",
                             bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT);
        end
        vecs++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== '0) begin
            errs++; $display("FAIL reset_resp_regs: got b=%b r=%b rd=%h expected 0", bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        vecs++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
            errs++; $display("FAIL ready_after_release: got %b expected 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        tick;
    endtask

    task automatic test_write;
        wait_n = 0; slv_err = 1'b0;
        bus.S_AXI_AWADDR = 12'h010; bus.S_AXI_AWPROT = 3'b001;
        bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        #1;
        vecs++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b110) begin
            errs++; $display("FAIL wr_addr_hs: got %b expected 110", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        tick;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        vecs++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT} !==
            {3'b101, 12'h010, 32'h12345678, 4'hF, 3'b001}) begin
            errs++; $display("FAIL wr_setup: got sel/en/wr=%b%b%b addr=%h wd=%h expected 101 010 12345678",
                             bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
        end
        tick;
        vecs++;
        if ({bus.PSEL, bus.PENABLE, bus.PREADY} !== 3'b111) begin
            errs++; $display("FAIL wr_access: got %b expected 111", {bus.PSEL, bus.PENABLE, bus.PREADY});
        end
        tick;
        vecs++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.PSEL, bus.PENABLE} !== 5'b10000) begin
            errs++; $display("FAIL wr_bresp_n3: got bv/bresp/sel/en=%b expected 10000",
                             {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.PSEL, bus.PENABLE});
        end
        bus.S_AXI_BREADY = 1'b1;
        tick;
        bus.S_AXI_BREADY = 1'b0;
        vecs++;
        if (bus.S_AXI_BVALID !== 1'b0) begin
            errs++; $display("FAIL wr_bvalid_clear: got %b expected 0", bus.S_AXI_BVALID);
        end
    endtask

    task automatic test_read_wait;
        int n;
        wait_n = 3; slv_rdata = 32'h87654321;
        bus.S_AXI_ARADDR = 12'h010; bus.S_AXI_ARPROT = 3'b010; bus.S_AXI_ARVALID = 1'b1;
        #1;
        vecs++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            errs++; $display("FAIL rd_addr_hs: got %b expected 1", bus.S_AXI_ARREADY);
        end
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        vecs++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT} !==
            {3'b100, 12'h010, 32'h0, 4'h0, 3'b010}) begin
            errs++; $display("FAIL rd_setup: got sel/en/wr=%b%b%b addr=%h wd=%h st=%h pr=%b expected 100 010 0 0 010",
                             bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT);
        end
        tick;
        n = 0;
        while (bus.PENABLE === 1'b1 && n < 20) begin
            n++;
            tick;
        end
        vecs++;
        if (n != 4) begin
            errs++; $display("FAIL rd_penable_cycles: got %0d expected 4", n);
        end
        vecs++;
        if (stab_err != 0) begin
            errs++; $display("FAIL apb_stable: got %0d unstable cycles expected 0", stab_err);
        end
        vecs++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== {1'b1, 2'b00, 32'h87654321}) begin
            errs++; $display("FAIL rd_rdata: got rv=%b rresp=%b rdata=%h expected 1 00 87654321",
                             bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_RREADY = 1'b0;
        wait_n = 0;
    endtask

    task automatic test_slverr;
        slv_err = 1'b1; slv_rdata = 32'hCAFEF00D;
        bus.S_AXI_ARADDR = 12'h020; bus.S_AXI_ARVALID = 1'b1;
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        tick;
        tick;
        vecs++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_RRESP} !== 3'b110) begin
            errs++; $display("FAIL slverr_rresp: got rv/rresp=%b expected 110", {bus.S_AXI_RVALID, bus.S_AXI_RRESP});
        end
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_RREADY = 1'b0;
        slv_err = 1'b0; slv_rdata = 32'h0BADF00D;
        bus.S_AXI_ARADDR = 12'h024; bus.S_AXI_ARVALID = 1'b1;
        #1;
        vecs++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            errs++; $display("FAIL slverr_next_ready: got %b expected 1", bus.S_AXI_ARREADY);
        end
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        tick;
        tick;
        vecs++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== {3'b100, 32'h0BADF00D}) begin
            errs++; $display("FAIL slverr_next_okay: got rv=%b rresp=%b rdata=%h expected 1 00 0badf00d",
                             bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_partial;
        bus.S_AXI_AWADDR = 12'h100; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = 12'h013; bus.S_AXI_ARVALID = 1'b1;
        #1;
        vecs++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b001) begin
            errs++; $display("FAIL aw_only_read_wins: got %b expected 001", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        vecs++;
        if ({bus.PADDR, bus.PWRITE} !== {12'h013, 1'b0}) begin
            errs++; $display("FAIL paddr_lsb: got addr=%h wr=%b expected 013 0", bus.PADDR, bus.PWRITE);
        end
        tick;
        tick;
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_RREADY = 1'b0;
        tick;
        vecs++;
        if ({bus.S_AXI_AWREADY, bus.PSEL} !== 2'b00) begin
            errs++; $display("FAIL aw_only_ignored: got awready/psel=%b expected 00", {bus.S_AXI_AWREADY, bus.PSEL});
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b1;
        tick;
        vecs++;
        if ({bus.S_AXI_WREADY, bus.PSEL} !== 2'b00) begin
            errs++; $display("FAIL w_only_ignored: got wready/psel=%b expected 00", {bus.S_AXI_WREADY, bus.PSEL});
        end
        bus.S_AXI_WVALID = 1'b0;
        tick;
    endtask

    task automatic test_bready_hold;
        bus.S_AXI_AWADDR = 12'h200; bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'h3;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        tick;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        tick;
        tick;
        bus.S_AXI_ARADDR = 12'h204; bus.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vecs++;
            if ({bus.S_AXI_BVALID, bus.S_AXI_ARREADY} !== 2'b10) begin
                errs++; $display("FAIL bhold_cycle%0d: got bvalid/arready=%b expected 10", i, {bus.S_AXI_BVALID, bus.S_AXI_ARREADY});
            end
            tick;
        end
        bus.S_AXI_BREADY = 1'b1;
        #1;
        vecs++;
        if (bus.S_AXI_ARREADY !== 1'b0) begin
            errs++; $display("FAIL bhold_hs_cycle: got arready=%b expected 0", bus.S_AXI_ARREADY);
        end
        tick;
        bus.S_AXI_BREADY = 1'b0;
        vecs++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            errs++; $display("FAIL bhold_after_hs: got arready=%b expected 1", bus.S_AXI_ARREADY);
        end
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        tick;
        tick;
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_arbitration;
        int w_left, r_left, nh;
        logic [5:0] ord;
        do_reset;
        tick;
        w_left = 3; r_left = 3; nh = 0; ord = '0;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        bus.S_AXI_AWADDR = 12'h080; bus.S_AXI_ARADDR = 12'h084;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        for (int c = 0; c < 100 && nh < 6; c++) begin
            #1;
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin
                ord = {ord[4:0], 1'b1}; w_left--; nh++;
            end
            if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) begin
                ord = {ord[4:0], 1'b0}; r_left--; nh++;
            end
            tick;
            bus.S_AXI_AWVALID = (w_left > 0); bus.S_AXI_WVALID = (w_left > 0);
            bus.S_AXI_ARVALID = (r_left > 0);
        end
        repeat (6) tick;
        vecs++;
        if (nh != 6) begin
            errs++; $display("FAIL arb_count: got %0d grants expected 6", nh);
        end
        vecs++;
        if (ord !== 6'b101010) begin
            errs++; $display("FAIL arb_grant_order: got %b expected 101010 (1=W)", ord);
        end
        vecs++;
        if (apb_ord[5:0] !== 6'b101010) begin
            errs++; $display("FAIL arb_apb_order: got %b expected 101010", apb_ord[5:0]);
        end
        vecs++;
        if (overlap_err != 0) begin
            errs++; $display("FAIL apb_overlap: got %0d expected 0", overlap_err);
        end
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic seen;
        wait_n = 10;
        bus.S_AXI_AWADDR = 12'h300; bus.S_AXI_WDATA = 32'h55AA55AA; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        tick;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        tick;
        tick;
        vecs++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            errs++; $display("FAIL rstmid_in_access: got %b expected 11", {bus.PSEL, bus.PENABLE});
        end
        #2;
        PRESETn = 1'b0;
        #1;
        vecs++;
        if ({bus.PSEL, bus.PENABLE, bus.PADDR} !== {2'b00, 12'h000}) begin
            errs++; $display("FAIL rstmid_async: got sel/en=%b%b addr=%h expected 00 000", bus.PSEL, bus.PENABLE, bus.PADDR);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick;
            if (bus.S_AXI_BVALID || bus.S_AXI_RVALID || bus.PSEL) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            errs++; $display("FAIL rstmid_no_resp: got activity=%b expected 0", seen);
        end
        wait_n = 0;
    endtask

    initial begin
        wait_n = 0; slv_rdata = '0; slv_err = 1'b0;
        test_reset;
        test_write;
        test_read_wait;
        test_slverr;
        test_partial;
        test_bready_hold;
        test_arbitration;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
